// File: rtl/chaotic_pkg.sv
// rtl/chaotic_pkg.sv - shared types and constants for the chaotic iteration controller
package chaotic_pkg;

    // Controller FSM states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_EMIT  = 2'd3
    } state_t;

    // IEEE-754 double constants used when building stimulus
    localparam logic [63:0] FP64_ZERO = 64'h0000_0000_0000_0000;
    localparam logic [63:0] FP64_ONE  = 64'h3FF0_0000_0000_0000;

    // Cycles to wait for an equation result before giving up
    localparam int DEFAULT_TIMEOUT = 1023;

endpackage

// File: rtl/chaotic_iter_ctrl.sv
// rtl/chaotic_iter_ctrl.sv - closed-loop iteration controller for the chaotic equation block
module chaotic_iter_ctrl
    import chaotic_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CNT_WIDTH  = 32,
    parameter int TIMEOUT    = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] x0,
    input  logic [DATA_WIDTH-1:0] y0,
    input  logic [DATA_WIDTH-1:0] z0,
    input  logic [CNT_WIDTH-1:0]  skip_num,
    input  logic [CNT_WIDTH-1:0]  iter_num,
    output logic                  eq_n_valid,
    output logic [DATA_WIDTH-1:0] eq_xn,
    output logic [DATA_WIDTH-1:0] eq_yn,
    output logic [DATA_WIDTH-1:0] eq_zn,
    input  logic                  eq_n1_valid,
    input  logic [DATA_WIDTH-1:0] eq_xn1,
    input  logic [DATA_WIDTH-1:0] eq_yn1,
    input  logic [DATA_WIDTH-1:0] eq_zn1,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_x,
    output logic [DATA_WIDTH-1:0] out_y,
    output logic [DATA_WIDTH-1:0] out_z,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout_err
);

    localparam int                     TMR_W       = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0]       TMR_LAST    = TMR_W'(TIMEOUT - 1);
    localparam logic [TMR_W-1:0]       TMR_ONE     = TMR_W'(1);
    localparam logic [CNT_WIDTH-1:0]   CNT_ONE     = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH:0]     CNT_ONE_EXT = (CNT_WIDTH + 1)'(1);

    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_x;
    logic [DATA_WIDTH-1:0] r_y;
    logic [DATA_WIDTH-1:0] r_z;
    logic [CNT_WIDTH-1:0]  r_skip_num;
    logic [CNT_WIDTH-1:0]  r_iter_num;
    logic [CNT_WIDTH-1:0]  r_skip_cnt;
    logic [CNT_WIDTH-1:0]  r_emit_cnt;
    logic [TMR_W-1:0]      r_timer;
    logic                  r_gap;
    logic                  r_done;
    logic                  r_timeout_err;

    logic                  w_accept_start;
    logic                  w_result;
    logic                  w_skip;
    logic                  w_hs;
    logic                  w_last;
    logic                  w_tmo;
    logic [CNT_WIDTH:0]    w_emit_next;

    // Event decode; r_gap is the one-cycle turnaround after a non-final accepted output
    always_comb begin
        w_accept_start = (r_state == ST_IDLE) && start && !abort;
        w_result       = (r_state == ST_WAIT) && eq_n1_valid;
        w_skip         = w_result && (r_skip_cnt < r_skip_num);
        w_hs           = (r_state == ST_EMIT) && !r_gap && out_ready;
        w_emit_next    = {1'b0, r_emit_cnt} + CNT_ONE_EXT;
        w_last         = (w_emit_next == {1'b0, r_iter_num});
        w_tmo          = (r_state == ST_WAIT) && !eq_n1_valid && (r_timer == TMR_LAST);
    end

    // Next-state logic; abort overrides every other transition
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept_start && (iter_num != '0)) begin
                    w_next = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                w_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (eq_n1_valid) begin
                    w_next = w_skip ? ST_ISSUE : ST_EMIT;
                end else if (w_tmo) begin
                    w_next = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (r_gap) begin
                    w_next = ST_ISSUE;
                end else if (w_hs && w_last) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (abort) begin
            w_next = ST_IDLE;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // State words: initial value on start, equation result in WAIT (even if aborting)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_x <= '0;
            r_y <= '0;
            r_z <= '0;
        end else if (w_accept_start) begin
            r_x <= x0;
            r_y <= y0;
            r_z <= z0;
        end else if (w_result) begin
            r_x <= eq_xn1;
            r_y <= eq_yn1;
            r_z <= eq_zn1;
        end
    end

    // Run parameters, iteration counters and wait timer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_skip_num <= '0;
            r_iter_num <= '0;
            r_skip_cnt <= '0;
            r_emit_cnt <= '0;
            r_timer    <= '0;
        end else begin
            if (w_accept_start) begin
                r_skip_num <= skip_num;
                r_iter_num <= iter_num;
                r_skip_cnt <= '0;
                r_emit_cnt <= '0;
            end
            if (w_skip) begin
                r_skip_cnt <= r_skip_cnt + CNT_ONE;
            end
            if (w_hs && !abort) begin
                r_emit_cnt <= w_emit_next[CNT_WIDTH-1:0];
            end
            if (r_state == ST_ISSUE) begin
                r_timer <= '0;
            end else if (r_state == ST_WAIT) begin
                r_timer <= r_timer + TMR_ONE;
            end
        end
    end

    // Completion pulse, sticky timeout flag and post-handshake turnaround
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_done        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_gap         <= 1'b0;
        end else begin
            r_done <= (w_accept_start && (iter_num == '0)) || (w_hs && w_last && !abort);
            r_gap  <= w_hs && !w_last && !abort;
            if (w_accept_start) begin
                r_timeout_err <= 1'b0;
            end else if (w_tmo && !abort) begin
                r_timeout_err <= 1'b1;
            end
        end
    end

    assign eq_n_valid  = (r_state == ST_ISSUE);
    assign eq_xn       = r_x;
    assign eq_yn       = r_y;
    assign eq_zn       = r_z;
    assign out_valid   = (r_state == ST_EMIT) && !r_gap;
    assign out_x       = r_x;
    assign out_y       = r_y;
    assign out_z       = r_z;
    assign busy        = (r_state != ST_IDLE);
    assign done        = r_done;
    assign timeout_err = r_timeout_err;

endmodule

// File: doc/chaotic_iter_ctrl.md
# chaotic_iter_ctrl

Iteration controller that drives the three-dimensional chaotic equation block in closed loop. It loads an initial state, issues one `n_valid` pulse per iteration, and captures `xn1/yn1/zn1` as the next state. It discards a programmable number of transient iterations, then presents each subsequent state on a ready/valid output toward the downstream sequence quantiser. Sits directly upstream of the equation block and owns its feedback path.

## Interface
Parameters:
- `DATA_WIDTH`, 64, width of each state word; must match the equation block's floating-point format.
- `CNT_WIDTH`, 32, width of the iteration counters.
- `TIMEOUT`, 1023, maximum cycles to wait for a result before aborting.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle start request; sampled only in IDLE.
- `abort`  in  1  synchronous abort; returns to IDLE from any state.
- `x0`, `y0`, `z0`  in  DATA_WIDTH each  initial state; latched on accepted `start`.
- `skip_num`  in  CNT_WIDTH  transient iterations to discard; latched on `start`.
- `iter_num`  in  CNT_WIDTH  states to emit; latched on `start`.
- `eq_n_valid`  out  1  one-cycle iteration request to the equation block.
- `eq_xn`, `eq_yn`, `eq_zn`  out  DATA_WIDTH each  current state, driven straight from the state registers.
- `eq_n1_valid`  in  1  result strobe from the equation block.
- `eq_xn1`, `eq_yn1`, `eq_zn1`  in  DATA_WIDTH each  next-state values.
- `out_valid`  out  1  emitted state available.
- `out_ready`  in  1  downstream accepts.
- `out_x`, `out_y`, `out_z`  out  DATA_WIDTH each  emitted state.
- `busy`  out  1  high whenever the controller is not in IDLE.
- `done`  out  1  one-cycle pulse when a run completes normally.
- `timeout_err`  out  1  sticky flag; cleared on the next accepted `start`.

## Operation
- States are IDLE, ISSUE, WAIT and EMIT.
- **IDLE**
  - `start=1` latches `x0/y0/z0` into the state registers, latches `skip_num`/`iter_num`, clears both counters and clears `timeout_err`.
  - If `iter_num==0`, go to IDLE, pulse `done` next cycle and issue nothing.
  - Otherwise go to ISSUE.
- **ISSUE**
  - Assert `eq_n_valid` for exactly one cycle.
  - Clear the wait timer and go to WAIT.
- **WAIT**
  - Each cycle, increment the timer.
  - On `eq_n1_valid`, load `eq_xn1/yn1/zn1` into the state registers.
    - If `skip_cnt < skip_num`: `skip_cnt++`, go to ISSUE.
    - Otherwise go to EMIT.
  - If the timer reaches `TIMEOUT` with no strobe: set `timeout_err` and go to IDLE with no `done`.
- **EMIT**
  - `out_valid=1`; `out_x/y/z` equal the state registers and stay stable until the handshake.
  - On `out_valid && out_ready`: `emit_cnt++`.
    - If `emit_cnt+1 == iter_num`: go to IDLE and pulse `done`.
    - Otherwise go to ISSUE.
- `eq_n1_valid` outside WAIT is ignored and the state registers are unchanged.
- `start` outside IDLE is ignored.
- `abort` has priority over every transition: go to IDLE, drop `out_valid`, no `done`; the state registers keep their value.
- Counters compare unsigned, with no wrap. `skip_num` up to 2^CNT_WIDTH−1 is legal.

## Timing
- Reset values:
  - State is IDLE.
  - `eq_n_valid`, `out_valid`, `busy`, `done`, `timeout_err` = 0.
  - State registers and `out_*` = 0.
  - Counters = 0.
- Accepted `start` at cycle 0 gives `eq_n_valid` high at cycle 1.
- With equation latency L (strobe at cycle 1+L), the state registers update at cycle 2+L.
  - After a skipped result, the next `eq_n_valid` is at cycle 2+L.
  - For an emitted result, `out_valid` rises at cycle 2+L.
- With `out_ready` held high, the handshake completes in the first EMIT cycle. The next `eq_n_valid` follows one cycle later, so the steady period is L+3 cycles per emitted state.
- `done` is high in the cycle after the final handshake, coincident with `busy` falling.
- A strobe and `abort` in the same cycle: `abort` wins, but the result is still latched.
- Asserting `rst_n` mid-run clears everything asynchronously. The equation block's outstanding result then arrives while the controller is in IDLE and is ignored.

## Structure
- Shared package (`chaotic_pkg`):
  - FSM state encoding.
  - IEEE-754 double constants `FP64_ZERO` and `FP64_ONE` for benches.
  - Default `TIMEOUT`.
- No sub-module is needed.
- A `chaotic_top` wrapper instantiates this block plus `Chaotic_Equations`, wiring `eq_*` to `n_valid`/`xn..zn`/`n1_valid`/`xn1..zn1`.

## Test plan
- **Basic run**: stub equation with L=6 and next state = input + 1.0; `x0=y0=z0=64'h3FF0000000000000`, `skip_num=0`, `iter_num=3`, `out_ready=1`.
  - `out_x` = 2.0 (`4000…`), 3.0 (`4008…`), 4.0 (`4010…`).
  - Emissions 9 cycles apart; `done` one cycle after the third handshake.
- **Transient skip**: `skip_num=5`, `iter_num=1`.
  - Six `eq_n_valid` pulses.
  - Single emission `out_x` = 7.0 (`401C…`).
- **Backpressure**: `out_ready=0` for 20 cycles during EMIT.
  - `out_*` stable and `out_valid` held.
  - No `eq_n_valid` until the handshake.
- **Timeout**: stub never strobes, `TIMEOUT=1023`.
  - `timeout_err=1` and `busy=0` exactly 1023 cycles after WAIT entry; no `done`.
  - The next `start` clears the flag.
- **Abort and start-while-busy**: `start` pulsed during WAIT is ignored; `abort` in WAIT returns to IDLE.
  - A late strobe is ignored.
  - A new `start` with `iter_num=1` completes normally.
- **Edge cases**: `iter_num=0` gives `done` with no `eq_n_valid`. `rst_n` low mid-EMIT clears all outputs immediately.
